// File: rtl/time_down_cnt.sv
// Track countdown timer: loads a duration in seconds and decrements once per prescaled second.
// State updates on the falling edge of CLK; the MIN/S split lags REMAIN_SEC by one cycle.
module time_down_cnt #(
   parameter int TICKS_PER_SEC = 1000000,
   parameter int SEC_W         = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [SEC_W-1:0] LOAD_SEC,
   input  logic             START,
   input  logic             PAUSE,
   output logic [SEC_W-1:0] REMAIN_SEC,
   output logic [7:0]       REMAIN_MIN,
   output logic [5:0]       REMAIN_S,
   output logic             RUNNING,
   output logic             EXPIRED,
   output logic             DONE
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [SEC_W-1:0] SIXTY      = SEC_W'(60);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      FIN    = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [PW-1:0]    presc, presc_n;
   logic [SEC_W-1:0] remain_n;
   logic             expired_n;
   logic [SEC_W-1:0] min_full;

   always_comb begin
      state_n   = state;
      presc_n   = presc;
      remain_n  = REMAIN_SEC;
      expired_n = 1'b0;
      if (LOAD) begin
         state_n  = IDLE;
         presc_n  = '0;
         remain_n = LOAD_SEC;
      end else begin
         case (state)
            IDLE: begin
               if (START && (REMAIN_SEC != '0)) begin
                  state_n = RUN;
                  presc_n = '0;
               end
            end
            RUN: begin
               if (PAUSE) begin
                  state_n = PAUSED;
               end else if (presc == PRESC_LAST) begin
                  presc_n = '0;
                  // Guarded so the count can never wrap below zero.
                  if (REMAIN_SEC != '0) begin
                     remain_n = REMAIN_SEC - 1'b1;
                  end
                  if (REMAIN_SEC <= SEC_W'(1)) begin
                     state_n   = FIN;
                     expired_n = 1'b1;
                  end
               end else begin
                  presc_n = presc + 1'b1;
               end
            end
            PAUSED: begin
               if (START && !PAUSE) begin
                  state_n = RUN;
               end
            end
            FIN: begin
               remain_n = '0;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign min_full = REMAIN_SEC / SIXTY;

   always_ff @(negedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         presc      <= '0;
         REMAIN_SEC <= '0;
         REMAIN_MIN <= '0;
         REMAIN_S   <= '0;
         EXPIRED    <= 1'b0;
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         REMAIN_SEC <= remain_n;
         EXPIRED    <= expired_n;
         REMAIN_MIN <= (min_full > SEC_W'(255)) ? 8'd255 : 8'(min_full);
         REMAIN_S   <= 6'(REMAIN_SEC % SIXTY);
      end
   end

   assign RUNNING = (state == RUN);
   assign DONE    = (state == FIN);

endmodule

// File: tb/tb_time_down_cnt.sv
// Bench for time_down_cnt: directed table, corner sequences and randomized run against a model.
module tb_time_down_cnt;

   localparam int T = 4;

   logic        CLK;
   logic        RST, LOAD, START, PAUSE;
   logic [15:0] LOAD_SEC;
   logic [15:0] REMAIN_SEC;
   logic [7:0]  REMAIN_MIN;
   logic [5:0]  REMAIN_S;
   logic        RUNNING, EXPIRED, DONE;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: mode 0 idle, 1 counting, 2 paused, 3 finished.
   int m_mode, m_ticks, m_rem, m_min, m_s;
   bit m_exp;

   time_down_cnt #(.TICKS_PER_SEC(T), .SEC_W(16)) dut (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .LOAD_SEC(LOAD_SEC),
      .START(START), .PAUSE(PAUSE), .REMAIN_SEC(REMAIN_SEC),
      .REMAIN_MIN(REMAIN_MIN), .REMAIN_S(REMAIN_S), .RUNNING(RUNNING),
      .EXPIRED(EXPIRED), .DONE(DONE)
   );

   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   function automatic void model_step();
      int nm, ns;
      if (RST) begin
         m_mode = 0; m_ticks = 0; m_rem = 0; m_min = 0; m_s = 0; m_exp = 0;
         return;
      end
      nm = (m_rem / 60 > 255) ? 255 : m_rem / 60;
      ns = m_rem % 60;
      m_exp = 0;
      if (LOAD) begin
         m_rem = int'(LOAD_SEC); m_ticks = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (START && m_rem > 0) begin m_mode = 1; m_ticks = 0; end
      end else if (m_mode == 1) begin
         if (PAUSE) m_mode = 2;
         else begin
            m_ticks = m_ticks + 1;
            if (m_ticks == T) begin
               m_ticks = 0;
               m_rem = m_rem - 1;
               if (m_rem == 0) begin m_mode = 3; m_exp = 1; end
            end
         end
      end else if (m_mode == 2) begin
         if (START && !PAUSE) m_mode = 1;
      end
      m_min = nm;
      m_s = ns;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("rem", int'(REMAIN_SEC), m_rem);
      check("min", int'(REMAIN_MIN), m_min);
      check("s", int'(REMAIN_S), m_s);
      check("running", int'(RUNNING), int'(m_mode == 1));
      check("done", int'(DONE), int'(m_mode == 3));
      check("expired", int'(EXPIRED), int'(m_exp));
   endtask

   // Inputs change just after a rising edge, DUT consumes them at the falling edge,
   // outputs are sampled at the following rising edge.
   task automatic cyc(input bit r, input bit ld, input int ls, input bit st, input bit pa);
      RST = r; LOAD = ld; LOAD_SEC = 16'(ls); START = st; PAUSE = pa;
      @(negedge CLK);
      model_step();
      @(posedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit rst, load, start, pause;
      int ls;
      int rem;
      bit run, exp, done;
   } vec_t;

   vec_t tbl[$];

   function automatic void addv(bit r, bit ld, int ls, bit st, bit pa,
                                int rem, bit run, bit ex, bit dn);
      vec_t v;
      v.rst = r; v.load = ld; v.ls = ls; v.start = st; v.pause = pa;
      v.rem = rem; v.run = run; v.exp = ex; v.done = dn;
      tbl.push_back(v);
   endfunction

   initial begin
      RST = 1; LOAD = 0; LOAD_SEC = 0; START = 0; PAUSE = 0;
      m_mode = 0; m_ticks = 0; m_rem = 0; m_min = 0; m_s = 0; m_exp = 0;

      // Countdown from 3: one step every 4 cycles, expiry pulse coincident with 0.
      addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 3, 0, 0, 3, 0, 0, 0);
      addv(0, 0, 0, 1, 0, 3, 1, 0, 0);
      for (int sec = 2; sec >= 0; sec--) begin
         for (int k = 0; k < 3; k++) addv(0, 0, 0, 0, 0, sec + 1, 1, 0, 0);
         addv(0, 0, 0, 0, 0, sec, sec != 0, sec == 0, sec == 0);
      end
      addv(0, 0, 0, 0, 0, 0, 0, 0, 1);

      @(posedge CLK);
      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].load, tbl[i].ls, tbl[i].start, tbl[i].pause);
         check($sformatf("tbl%0d_rem", i), int'(REMAIN_SEC), tbl[i].rem);
         check($sformatf("tbl%0d_run", i), int'(RUNNING), int'(tbl[i].run));
         check($sformatf("tbl%0d_exp", i), int'(EXPIRED), int'(tbl[i].exp));
         check($sformatf("tbl%0d_done", i), int'(DONE), int'(tbl[i].done));
      end

      // DONE ignores START/PAUSE; a fresh LOAD 1 expires 4 cycles after START.
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 1, 1);
      check("done_hold", int'(DONE), 1);
      check("done_noexp", int'(EXPIRED), 0);
      check("done_rem", int'(REMAIN_SEC), 0);
      cyc(0, 1, 1, 0, 0);
      check("reload_done", int'(DONE), 0);
      cyc(0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 0);
         check("one_sec_wait", int'(EXPIRED), 0);
      end
      cyc(0, 0, 0, 0, 0);
      check("one_sec_exp", int'(EXPIRED), 1);
      check("one_sec_rem", int'(REMAIN_SEC), 0);

      // Pause preserves the partial second.
      cyc(0, 1, 5, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(6);
      check("pre_pause_rem", int'(REMAIN_SEC), 4);
      cyc(0, 0, 0, 0, 1);
      for (int k = 0; k < 20; k++) cyc(0, 0, 0, k[0], 1);
      check("paused_rem", int'(REMAIN_SEC), 4);
      check("paused_run", int'(RUNNING), 0);
      cyc(0, 0, 0, 1, 0);
      check("resume_run", int'(RUNNING), 1);
      cyc(0, 0, 0, 0, 0);
      check("resume_c1", int'(REMAIN_SEC), 4);
      cyc(0, 0, 0, 0, 0);
      check("resume_c2", int'(REMAIN_SEC), 3);

      // Minutes/seconds split with one cycle of latency.
      cyc(0, 1, 125, 0, 0);
      check("split_rem", int'(REMAIN_SEC), 125);
      idle(1);
      check("split_min", int'(REMAIN_MIN), 2);
      check("split_s", int'(REMAIN_S), 5);
      cyc(0, 1, 3725, 0, 0); idle(1);
      check("split3725_min", int'(REMAIN_MIN), 62);
      check("split3725_s", int'(REMAIN_S), 5);
      cyc(0, 1, 65535, 0, 0); idle(1);
      check("sat_min", int'(REMAIN_MIN), 255);
      check("sat_s", int'(REMAIN_S), 15);
      cyc(0, 0, 0, 1, 0); idle(4);
      check("full_scale_dec", int'(REMAIN_SEC), 65534);

      // LOAD beats PAUSE and START mid-run.
      cyc(0, 1, 2, 0, 0); cyc(0, 0, 0, 1, 0); idle(1);
      cyc(0, 1, 7, 1, 1);
      check("ldpri_rem", int'(REMAIN_SEC), 7);
      check("ldpri_run", int'(RUNNING), 0);
      check("ldpri_exp", int'(EXPIRED), 0);
      idle(1);
      check("ldpri_idle", int'(RUNNING), 0);

      // Reset on the wrap edge of the last second.
      cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0); idle(3);
      cyc(1, 0, 0, 0, 0);
      check("rst_rem", int'(REMAIN_SEC), 0);
      check("rst_exp", int'(EXPIRED), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_min", int'(REMAIN_MIN), 0);
      cyc(0, 0, 0, 1, 0);
      check("rst_exp2", int'(EXPIRED), 0);
      check("zero_start", int'(RUNNING), 0);
      idle(1);
      check_model();

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         int ls;
         ls = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535))
                                           : int'($urandom_range(0, 6));
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0, ls,
             $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
         check_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/time_down_cnt.md
Name: time_down_cnt

Overview:
Countdown counterpart to the elapsed-time counter. It loads a track duration in seconds and decrements it once per second, derived from CLK by a prescaler. It supports start/pause/resume and flags expiry so the player control can advance to the next track. It also provides a minutes/seconds split of the remaining time for the display path.

Parameters:
TICKS_PER_SEC, 1000000, CLK cycles per second; the prescaler counts 0..TICKS_PER_SEC-1.
SEC_W, 16, width of the seconds count.

Ports:
CLK  input  1  system clock; all state updates on the falling edge.
RST  input  1  synchronous, active-high reset.
LOAD  input  1  load LOAD_SEC into the remaining-time register.
LOAD_SEC  input  SEC_W  duration to load, in seconds.
START  input  1  start, or resume after pause.
PAUSE  input  1  pause the countdown.
REMAIN_SEC  output  SEC_W  remaining seconds (registered).
REMAIN_MIN  output  8  REMAIN_SEC/60, saturated at 255 (registered).
REMAIN_S  output  6  REMAIN_SEC mod 60 (registered).
RUNNING  output  1  high while in the RUN state.
EXPIRED  output  1  one-cycle pulse when the count reaches 0.
DONE  output  1  level; high in the DONE state.

Behaviour:
- Reset values on RST=1: state IDLE, prescaler 0, REMAIN_SEC 0, REMAIN_MIN 0, REMAIN_S 0, RUNNING 0, EXPIRED 0, DONE 0.
- Control priority: RST > LOAD > PAUSE > START.
- States: IDLE, RUN, PAUSED, DONE.
- LOAD, in any state:
  - REMAIN_SEC <= LOAD_SEC, prescaler <= 0, state <= IDLE.
  - EXPIRED <= 0.
  - Aborts an ongoing countdown.
- IDLE:
  - START with REMAIN_SEC>0 -> RUN, prescaler <= 0.
  - START with REMAIN_SEC=0 is ignored.
- RUN:
  - Prescaler increments every cycle.
  - At TICKS_PER_SEC-1 it wraps to 0 and REMAIN_SEC decrements by 1 on the same edge.
  - If REMAIN_SEC was 1 at a wrap: REMAIN_SEC becomes 0, state -> DONE, EXPIRED=1 for exactly that one cycle.
  - PAUSE -> PAUSED; the prescaler freezes and that edge does not increment it.
- PAUSED:
  - Prescaler and REMAIN_SEC hold.
  - START -> RUN; prescaler resumes from the held value, so the partial second is preserved.
  - PAUSE and START together: stay PAUSED.
- DONE:
  - Holds REMAIN_SEC=0.
  - START and PAUSE are ignored.
  - Exit only via LOAD or RST.
- RUNNING is high iff the state is RUN. DONE is high iff the state is DONE. Both are registered with the state.
- REMAIN_MIN and REMAIN_S are computed from REMAIN_SEC and registered: 1-cycle latency after REMAIN_SEC changes.
- Example split: REMAIN_SEC=3725 -> MIN=62, S=5. Values of 15360 and above give MIN=255.
- No underflow: REMAIN_SEC never wraps below 0.
- Full-scale LOAD_SEC=65535 counts down normally.
- Reset mid-RUN clears everything on the next falling edge; EXPIRED is not asserted.

Test Plan (TICKS_PER_SEC=4):
- Reset, then LOAD_SEC=3, LOAD, START -> RUNNING=1 and REMAIN_SEC steps 3,2,1,0, one step every 4 cycles. EXPIRED is a single-cycle pulse coincident with 0. DONE=1 and RUNNING=0 afterwards.
- LOAD 5, START, PAUSE after 6 cycles (REMAIN_SEC=4, prescaler=2), hold 20 cycles, then START -> REMAIN_SEC stays 4 while paused and decrements to 3 exactly 2 cycles after resume.
- LOAD 125 -> one cycle after REMAIN_SEC=125, REMAIN_MIN=2 and REMAIN_S=5. LOAD 65535 -> MIN=255, S=15.
- In RUN with REMAIN_SEC=2, assert LOAD (LOAD_SEC=7) together with PAUSE and START -> LOAD wins: state IDLE, REMAIN_SEC=7, RUNNING=0, no EXPIRED.
- Assert RST mid-RUN with REMAIN_SEC=1 at the prescaler wrap cycle -> all outputs 0 and EXPIRED never pulses. START with REMAIN_SEC=0 is then ignored (RUNNING stays 0).
- In DONE, pulse START and PAUSE -> no state change and no further EXPIRED. Then LOAD 1, START -> expires after 4 cycles.
